// File: rtl/oib_responder.sv
// Far-end responder for the 9-bit off-chip byte bus: decodes request frames, performs one
// 32-bit local access and returns a status (plus read data) response on the inbound lane.
module oib_responder #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [7:0]          ob_data_i,
  input  logic                ob_pty_i,
  output logic [7:0]          ib_data_o,
  output logic                ib_pty_o,
  output logic                mem_cyc_o,
  output logic                mem_we_o,
  output logic [31:0]         mem_adr_o,
  output logic [31:0]         mem_dat_o,
  input  logic                mem_ack_i,
  input  logic [31:0]         mem_dat_i,
  output logic                busy_o,
  output logic [ERRCNT_W-1:0] err_count_o
);

  typedef enum logic [2:0] {StIdle, StAddr, StWdata, StMem, StResp, StErr} state_e;

  localparam logic [7:0]  CmdRd   = 8'h10;
  localparam logic [7:0]  CmdWr   = 8'h20;
  localparam logic [7:0]  StsRd   = 8'h01;
  localparam logic [7:0]  StsWr   = 8'h02;
  localparam logic [7:0]  ErrPty  = 8'hE0;
  localparam logic [7:0]  ErrTmo  = 8'hE1;
  localparam logic [7:0]  ErrIdle = 8'hE2;
  localparam logic [7:0]  ErrOp   = 8'hE3;
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  state_e              state, state_nx;
  logic [1:0]          beat_cnt, beat_cnt_nx;
  logic [15:0]         tmo_cnt, tmo_cnt_nx;
  logic [31:0]         rdata, rdata_nx;
  logic [2:0]          left, left_nx;
  logic [7:0]          ib_data_nx;
  logic                ib_valid_nx;
  logic                ib_pty_nx;
  logic                mem_cyc_nx, mem_we_nx;
  logic [31:0]         mem_adr_nx, mem_dat_nx;
  logic [ERRCNT_W-1:0] err_count_nx;
  logic                raise_err;
  logic [7:0]          err_code;
  logic                ob_idle, ob_odd;

  assign ob_idle = ({ob_pty_i, ob_data_i} == 9'h000);
  assign ob_odd  = ^{ob_pty_i, ob_data_i};

  always_comb begin
    state_nx     = state;
    beat_cnt_nx  = beat_cnt;
    tmo_cnt_nx   = tmo_cnt;
    rdata_nx     = rdata;
    left_nx      = left;
    ib_data_nx   = 8'h00;
    ib_valid_nx  = 1'b0;
    mem_cyc_nx   = mem_cyc_o;
    mem_we_nx    = mem_we_o;
    mem_adr_nx   = mem_adr_o;
    mem_dat_nx   = mem_dat_o;
    err_count_nx = err_count_o;
    raise_err    = 1'b0;
    err_code     = 8'h00;

    unique case (state)
      StIdle: begin
        if (!ob_idle) begin
          if (!ob_odd) begin
            raise_err = 1'b1;
            err_code  = ErrPty;
          end else if (ob_data_i == CmdRd || ob_data_i == CmdWr) begin
            state_nx    = StAddr;
            mem_we_nx   = (ob_data_i == CmdWr);
            beat_cnt_nx = 2'd0;
          end else begin
            raise_err = 1'b1;
            err_code  = ErrOp;
          end
        end
      end
      StAddr, StWdata: begin
        if (ob_idle) begin
          raise_err = 1'b1;
          err_code  = ErrIdle;
        end else if (!ob_odd) begin
          raise_err = 1'b1;
          err_code  = ErrPty;
        end else begin
          beat_cnt_nx = beat_cnt + 2'd1;
          if (state == StAddr) begin
            mem_adr_nx = {mem_adr_o[23:0], ob_data_i};
          end else begin
            mem_dat_nx = {mem_dat_o[23:0], ob_data_i};
          end
          if (beat_cnt == 2'd3) begin
            if (state == StAddr && mem_we_o) begin
              state_nx = StWdata;
            end else begin
              state_nx   = StMem;
              mem_cyc_nx = 1'b1;
              tmo_cnt_nx = 16'd0;
            end
          end
        end
      end
      StMem: begin
        // Ack is checked before the timeout so a coincident ack still completes the access.
        if (mem_ack_i) begin
          mem_cyc_nx  = 1'b0;
          rdata_nx    = mem_dat_i;
          ib_data_nx  = mem_we_o ? StsWr : StsRd;
          ib_valid_nx = 1'b1;
          left_nx     = mem_we_o ? 3'd0 : 3'd4;
          state_nx    = StResp;
        end else if (tmo_cnt == TmoLast) begin
          mem_cyc_nx = 1'b0;
          raise_err  = 1'b1;
          err_code   = ErrTmo;
        end else begin
          tmo_cnt_nx = tmo_cnt + 16'd1;
        end
      end
      StResp: begin
        if (left == 3'd0) begin
          state_nx = StIdle;
        end else begin
          ib_data_nx  = rdata[31:24];
          ib_valid_nx = 1'b1;
          rdata_nx    = {rdata[23:0], 8'h00};
          left_nx     = left - 3'd1;
        end
      end
      StErr:   state_nx = StIdle;
      default: state_nx = StIdle;
    endcase

    if (raise_err) begin
      state_nx    = StErr;
      ib_data_nx  = err_code;
      ib_valid_nx = 1'b1;
      if (err_count_o != '1) begin
        err_count_nx = err_count_o + ERRCNT_W'(1);
      end
    end
  end

  // A valid beat always carries odd parity, so a zero data byte never reads as the IDLE word.
  assign ib_pty_nx = ib_valid_nx & ~^ib_data_nx;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= StIdle;
      beat_cnt    <= 2'd0;
      tmo_cnt     <= 16'd0;
      rdata       <= 32'h0;
      left        <= 3'd0;
      ib_data_o   <= 8'h00;
      ib_pty_o    <= 1'b0;
      mem_cyc_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_adr_o   <= 32'h0;
      mem_dat_o   <= 32'h0;
      busy_o      <= 1'b0;
      err_count_o <= '0;
    end else begin
      state       <= state_nx;
      beat_cnt    <= beat_cnt_nx;
      tmo_cnt     <= tmo_cnt_nx;
      rdata       <= rdata_nx;
      left        <= left_nx;
      ib_data_o   <= ib_data_nx;
      ib_pty_o    <= ib_pty_nx;
      mem_cyc_o   <= mem_cyc_nx;
      mem_we_o    <= mem_we_nx;
      mem_adr_o   <= mem_adr_nx;
      mem_dat_o   <= mem_dat_nx;
      busy_o      <= (state_nx != StIdle);
      err_count_o <= err_count_nx;
    end
  end

endmodule

// File: tb/tb_oib_responder.sv
// Bench for oib_responder: directed and random frames checked against a frame-level
// reference model of the expected response beats, latency and access duration.
module tb_oib_responder;

  localparam int unsigned TMO  = 8;
  localparam int unsigned ECW  = 8;
  localparam int          EMAX = 255;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      ob_data;
  logic            ob_pty;
  logic [7:0]      ib_data;
  logic            ib_pty;
  logic            mem_cyc;
  logic            mem_we;
  logic [31:0]     mem_adr;
  logic [31:0]     mem_dat;
  logic            mem_ack;
  logic [31:0]     mem_rdat;
  logic            busy;
  logic [ECW-1:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_errs = 0;

  logic [8:0] got_q[$];
  logic [7:0] exp_q[$];
  int first_k;
  int mem_cycles;

  always #5 clk = ~clk;

  oib_responder #(
    .TIMEOUT (TMO),
    .ERRCNT_W(ECW)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .ob_data_i  (ob_data),
    .ob_pty_i   (ob_pty),
    .ib_data_o  (ib_data),
    .ib_pty_o   (ib_pty),
    .mem_cyc_o  (mem_cyc),
    .mem_we_o   (mem_we),
    .mem_adr_o  (mem_adr),
    .mem_dat_o  (mem_dat),
    .mem_ack_i  (mem_ack),
    .mem_dat_i  (mem_rdat),
    .busy_o     (busy),
    .err_count_o(err_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one request frame (optionally corrupted), services the access and collects the response.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] adr,
                           input logic [31:0] wdat, input int bad_idx, input int idle_idx,
                           input int ack_d, input logic [31:0] rd);
    logic [7:0] fr [9];
    int full_len, n_send, exp_k, exp_cyc;
    bit done, ok_access;
    fr[0] = cmd;
    for (int i = 0; i < 4; i++) begin
      fr[1+i] = adr[31-8*i -: 8];
      fr[5+i] = wdat[31-8*i -: 8];
    end
    full_len = (cmd == 8'h10) ? 5 : (cmd == 8'h20) ? 9 : 1;
    n_send = full_len;

    // Reference model: frame-level outcome.
    exp_q.delete();
    ok_access = 1'b0;
    exp_cyc = 0;
    if (bad_idx >= 0 && bad_idx < full_len) begin
      exp_q.push_back(8'hE0);
      n_send = bad_idx + 1;
      exp_k = bad_idx;
    end else if (idle_idx >= 1 && idle_idx < full_len) begin
      exp_q.push_back(8'hE2);
      n_send = idle_idx + 1;
      exp_k = idle_idx;
    end else if (cmd != 8'h10 && cmd != 8'h20) begin
      exp_q.push_back(8'hE3);
      exp_k = 0;
    end else if (ack_d < 0 || ack_d >= int'(TMO)) begin
      exp_q.push_back(8'hE1);
      exp_k = n_send + int'(TMO) - 1;
      exp_cyc = int'(TMO);
    end else begin
      ok_access = 1'b1;
      exp_k = n_send + ack_d;
      exp_cyc = ack_d + 1;
      if (cmd == 8'h10) begin
        exp_q.push_back(8'h01);
        for (int i = 0; i < 4; i++) exp_q.push_back(rd[31-8*i -: 8]);
      end else begin
        exp_q.push_back(8'h02);
      end
    end
    if (!ok_access) exp_errs = (exp_errs >= EMAX) ? EMAX : exp_errs + 1;

    got_q.delete();
    first_k = -1;
    mem_cycles = 0;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (k < n_send) begin
        if (k == idle_idx) begin
          ob_data = 8'h00;
          ob_pty = 1'b0;
        end else begin
          ob_data = fr[k];
          ob_pty = (~^fr[k]) ^ (k == bad_idx);
        end
      end else begin
        ob_data = 8'h00;
        ob_pty = 1'b0;
      end
      mem_ack = 1'b0;
      mem_rdat = $urandom;
      if (mem_cyc) begin
        if (mem_cycles == ack_d) begin
          mem_ack = 1'b1;
          mem_rdat = rd;
        end
        mem_cycles++;
      end
      step();
      if ({ib_pty, ib_data} != 9'h000) begin
        if (first_k < 0) first_k = k;
        got_q.push_back({ib_pty, ib_data});
      end else if (got_q.size() > 0) begin
        done = 1'b1;
      end
    end
    mem_ack = 1'b0;
    ob_data = 8'h00;
    ob_pty = 1'b0;

    check({tag, "/complete"}, 64'(done), 64'd1);
    check({tag, "/nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s/beat%0d", tag, i), 64'(got_q[i]), 64'({~^exp_q[i], exp_q[i]}));
    check({tag, "/latency"}, 64'(first_k), 64'(exp_k));
    check({tag, "/cyc_len"}, 64'(mem_cycles), 64'(exp_cyc));
    check({tag, "/busy_end"}, 64'(busy), 64'd0);
    check({tag, "/errcnt"}, 64'(err_count), 64'(exp_errs));
    if (ok_access) begin
      check({tag, "/adr"}, 64'(mem_adr), 64'(adr));
      check({tag, "/we"}, 64'(mem_we), 64'(cmd == 8'h20));
      if (cmd == 8'h20) check({tag, "/wdat"}, 64'(mem_dat), 64'(wdat));
    end
  endtask

  initial begin
    logic [7:0]  rcmd;
    logic [31:0] radr, rdat, rrd;
    int          rdel;
    rst = 1'b1;
    ob_data = 8'h00;
    ob_pty = 1'b0;
    mem_ack = 1'b0;
    mem_rdat = 32'h0;
    step();
    step();
    check("rst/ib", 64'({ib_pty, ib_data}), 64'd0);
    check("rst/cyc", 64'(mem_cyc), 64'd0);
    check("rst/we", 64'(mem_we), 64'd0);
    check("rst/adr", 64'(mem_adr), 64'd0);
    check("rst/dat", 64'(mem_dat), 64'd0);
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/err", 64'(err_count), 64'd0);
    rst = 1'b0;
    step();

    run_frame("rd_basic", 8'h10, 32'h0000_0100, 32'h0, -1, -1, 3, 32'hDEADBEEF);
    run_frame("wr_basic", 8'h20, 32'h1234_5678, 32'hCAFEF00D, -1, -1, 0, 32'h0);
    run_frame("pty_addr3", 8'h10, 32'h1122_3344, 32'h0, 3, -1, 0, 32'h0);
    run_frame("rd_after_pty", 8'h10, 32'h0000_0100, 32'h0, -1, -1, 1, 32'h00FF_0080);
    run_frame("rd_earliest", 8'h10, 32'hA5A5_5A5A, 32'h0, -1, -1, 0, 32'h0102_0304);
    run_frame("rd_timeout", 8'h10, 32'h0000_0040, 32'h0, -1, -1, -1, 32'h0);
    run_frame("wr_ack_last", 8'h20, 32'h0BAD_F00D, 32'h7777_8888, -1, -1, int'(TMO) - 1, 32'h0);
    run_frame("bad_op", 8'h31, 32'h0, 32'h0, -1, -1, 0, 32'h0);
    run_frame("pty_cmd", 8'h10, 32'h0, 32'h0, 0, -1, 0, 32'h0);
    run_frame("idle_addr2", 8'h10, 32'hFFEE_DDCC, 32'h0, -1, 3, 0, 32'h0);
    run_frame("idle_wdata", 8'h20, 32'h1, 32'h2, -1, 6, 0, 32'h0);
    run_frame("pty_wdata", 8'h20, 32'h1, 32'h8899_AABB, 7, -1, 0, 32'h0);

    for (int n = 0; n < 12; n++) begin
      rcmd = ($urandom_range(0, 1) == 0) ? 8'h10 : 8'h20;
      radr = $urandom;
      rdat = $urandom;
      rrd = $urandom;
      rdel = int'($urandom_range(0, TMO + 1));
      run_frame($sformatf("rand%0d", n), rcmd, radr, rdat, -1, -1, rdel, rrd);
    end

    // Reset in the middle of an access; a late ack must not resurrect it.
    ob_data = 8'h10; ob_pty = ~^ob_data; step();
    for (int i = 0; i < 4; i++) begin
      ob_data = 8'h40 + 8'(i);
      ob_pty = ~^ob_data;
      step();
    end
    ob_data = 8'h00; ob_pty = 1'b0;
    step();
    check("mrst/cyc_before", 64'(mem_cyc), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_errs = 0;
    check("mrst/cyc", 64'(mem_cyc), 64'd0);
    check("mrst/busy", 64'(busy), 64'd0);
    check("mrst/ib", 64'({ib_pty, ib_data}), 64'd0);
    check("mrst/err", 64'(err_count), 64'd0);
    mem_ack = 1'b1;
    mem_rdat = 32'h1357_9BDF;
    step();
    mem_ack = 1'b0;
    check("late_ack/cyc", 64'(mem_cyc), 64'd0);
    check("late_ack/busy", 64'(busy), 64'd0);
    check("late_ack/ib", 64'({ib_pty, ib_data}), 64'd0);
    step();
    check("late_ack/ib2", 64'({ib_pty, ib_data}), 64'd0);
    run_frame("rd_after_rst", 8'h10, 32'hC0DE_0000, 32'h0, -1, -1, 2, 32'h8000_0001);

    for (int n = 0; n < (1 << ECW) + 3; n++) begin
      run_frame("sat", 8'h31, 32'h0, 32'h0, -1, -1, 0, 32'h0);
    end
    check("sat/final", 64'(err_count), 64'(EMAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
